// File: rtl/lemming_sched_if.sv
// lemming_sched_if: level-map inputs, per-lemming status vectors and grant report for lemming_sched
//   ground/bump_left/bump_right/dig : per-lemming levels from the environment (N bits each)
//   walk_left/walk_right/aaah/digging/splat : per-lemming status decoded from registered state
//   gnt_vld/gnt_idx : which lemming (if any) committed on the last edge
interface lemming_sched_if #(parameter int N = 4);
  logic [N-1:0] ground;
  logic [N-1:0] bump_left;
  logic [N-1:0] bump_right;
  logic [N-1:0] dig;
  logic [N-1:0] walk_left;
  logic [N-1:0] walk_right;
  logic [N-1:0] aaah;
  logic [N-1:0] digging;
  logic [N-1:0] splat;
  logic gnt_vld;
  logic [$clog2(N)-1:0] gnt_idx;
  modport master (
    output ground, bump_left, bump_right, dig,
    input  walk_left, walk_right, aaah, digging, splat, gnt_vld, gnt_idx
  );
  modport slave (
    input  ground, bump_left, bump_right, dig,
    output walk_left, walk_right, aaah, digging, splat, gnt_vld, gnt_idx
  );
endinterface

// File: rtl/lemming_sched.sv
// lemming_sched: N walker FSMs sharing one round-robin next-state commit path
//   clk    : rising-edge clock
//   areset : asynchronous active-high reset (all lemmings WALK_L, counters/pointer cleared)
//   bus    : slave side of lemming_sched_if (level inputs in, status vectors and grant out)
module lemming_sched #(
  parameter int N = 4,
  parameter int SPLAT_CYCLES = 20,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic areset,
  lemming_sched_if.slave bus
);
  localparam int IW = $clog2(N);
  typedef enum logic [2:0] {WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT} st_e;
  st_e state_q [N];
  st_e state_d [N];
  st_e cand [N];
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0] req;
  logic [IW-1:0] ptr_q, ptr_d, gnt_idx_q, gnt_idx_d, k;
  logic gnt_vld_q, gnt_vld_d, any;
  function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int j);
    return IW'((int'(p) + j) % N);
  endfunction
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cand[i] = state_q[i];
      case (state_q[i])
        WALK_L: cand[i] = !bus.ground[i] ? FALL_L : bus.dig[i] ? DIG_L : bus.bump_left[i] ? WALK_R : WALK_L;
        WALK_R: cand[i] = !bus.ground[i] ? FALL_R : bus.dig[i] ? DIG_R : bus.bump_right[i] ? WALK_L : WALK_R;
        FALL_L: cand[i] = bus.ground[i] ? (int'(cnt_q[i]) >= SPLAT_CYCLES ? SPLAT : WALK_L) : FALL_L;
        FALL_R: cand[i] = bus.ground[i] ? (int'(cnt_q[i]) >= SPLAT_CYCLES ? SPLAT : WALK_R) : FALL_R;
        DIG_L:  cand[i] = !bus.ground[i] ? FALL_L : DIG_L;
        DIG_R:  cand[i] = !bus.ground[i] ? FALL_R : DIG_R;
        default: cand[i] = state_q[i];
      endcase
      req[i] = cand[i] != state_q[i];
    end
  end
  // Descending scan so the last hit is the first requester at or after ptr.
  always_comb begin
    k = ptr_q;
    for (int j = N - 1; j >= 0; j--)
      if (req[rot(ptr_q, j)]) k = rot(ptr_q, j);
    any = |req;
  end
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = (any && k == IW'(i)) ? cand[i] : state_q[i];
      // In-fall state before the edge: entry edge loads 0, each later edge counts.
      cnt_d[i] = (state_q[i] == FALL_L || state_q[i] == FALL_R) ? (&cnt_q[i] ? cnt_q[i] : cnt_q[i] + 1'b1) : '0;
    end
    ptr_d = any ? rot(k, 1) : ptr_q;
    gnt_vld_d = any;
    gnt_idx_d = any ? k : gnt_idx_q;
  end
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= WALK_L;
        cnt_q[i] <= '0;
      end
      ptr_q <= '0;
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      ptr_q <= ptr_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end
  always_comb begin
    bus.walk_left = '0;
    bus.walk_right = '0;
    bus.aaah = '0;
    bus.digging = '0;
    bus.splat = '0;
    for (int i = 0; i < N; i++) begin
      bus.walk_left[i] = state_q[i] == WALK_L;
      bus.walk_right[i] = state_q[i] == WALK_R;
      bus.aaah[i] = state_q[i] == FALL_L || state_q[i] == FALL_R;
      bus.digging[i] = state_q[i] == DIG_L || state_q[i] == DIG_R;
      bus.splat[i] = state_q[i] == SPLAT;
    end
  end
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.gnt_idx = gnt_idx_q;
endmodule

// File: tb/tb_lemming_sched.sv
// tb_lemming_sched: directed stimulus with a grant scoreboard for lemming_sched
module tb_lemming_sched;
  localparam int N = 4;
  localparam logic [4:0] WL = 5'b10000, WR = 5'b01000, AA = 5'b00100, DG = 5'b00010, SP = 5'b00001;
  typedef struct {int idx; logic [4:0] st;} exp_t;
  logic clk = 1'b0;
  logic areset = 1'b1;
  exp_t q[$];
  exp_t e;
  int n_chk = 0;
  int n_pass = 0;
  lemming_sched_if #(.N(N)) bus();
  lemming_sched #(.N(N), .SPLAT_CYCLES(20), .CNT_W(5)) dut (.clk(clk), .areset(areset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask
  function automatic logic [4:0] st_of(input int i);
    return {bus.walk_left[i], bus.walk_right[i], bus.aaah[i], bus.digging[i], bus.splat[i]};
  endfunction
  task automatic push(input int i, input logic [4:0] s);
    exp_t x;
    x.idx = i;
    x.st = s;
    q.push_back(x);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_reset();
    #2 areset = 1'b1;
    #1 areset = 1'b0;
    cyc(1);
  endtask
  always @(negedge clk) begin
    if (bus.gnt_vld) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_gnt: got idx %0d want no grant", bus.gnt_idx);
      end else begin
        e = q.pop_front();
        chk("gnt_idx", 32'(bus.gnt_idx), 32'(e.idx));
        chk("gnt_state", 32'(st_of(e.idx)), 32'(e.st));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end
  initial begin
    bus.ground = 4'hF;
    bus.bump_left = '0;
    bus.bump_right = '0;
    bus.dig = '0;
    #1;
    chk("rst_wl", 32'(bus.walk_left), 32'hF);
    chk("rst_wr", 32'(bus.walk_right), 32'h0);
    chk("rst_aaah", 32'(bus.aaah), 32'h0);
    chk("rst_dig", 32'(bus.digging), 32'h0);
    chk("rst_splat", 32'(bus.splat), 32'h0);
    chk("rst_gnt", 32'(bus.gnt_vld), 32'h0);
    cyc(1);
    areset = 1'b0;
    repeat (3) begin
      cyc(1);
      chk("idle_wl", 32'(bus.walk_left), 32'hF);
      chk("idle_gnt", 32'(bus.gnt_vld), 32'h0);
    end
    bus.bump_left = 4'hF;
    push(0, WR);
    cyc(1);
    bus.bump_left = '0;
    chk("bump1_wr", 32'(bus.walk_right), 32'h1);
    cyc(1);
    chk("bump1_lost_wr", 32'(bus.walk_right), 32'h1);
    chk("bump1_lost_wl", 32'(bus.walk_left), 32'hE);
    chk("bump1_lost_gnt", 32'(bus.gnt_vld), 32'h0);
    #2 areset = 1'b1;
    #1;
    chk("async_wl", 32'(bus.walk_left), 32'hF);
    chk("async_wr", 32'(bus.walk_right), 32'h0);
    chk("async_gnt", 32'(bus.gnt_vld), 32'h0);
    cyc(1);
    areset = 1'b0;
    bus.bump_left = 4'hF;
    for (int j = 0; j < N; j++) push(j, WR);
    cyc(4);
    chk("bumpall_wr", 32'(bus.walk_right), 32'hF);
    bus.bump_left = '0;
    cyc(1);
    chk("bumpall_idle", 32'(bus.gnt_vld), 32'h0);
    pulse_reset();
    bus.ground = 4'hB;
    push(2, AA);
    cyc(1);
    chk("fall2_aaah", 32'(bus.aaah), 32'h4);
    chk("fall2_wl", 32'(bus.walk_left), 32'hB);
    cyc(4);
    bus.ground = 4'hF;
    push(2, WL);
    cyc(1);
    chk("land2_wl", 32'(bus.walk_left), 32'hF);
    chk("land2_splat", 32'(bus.splat), 32'h0);
    bus.ground = 4'hD;
    push(1, AA);
    cyc(25);
    bus.ground = 4'hF;
    push(1, SP);
    cyc(1);
    chk("splat1", 32'(bus.splat), 32'h2);
    chk("splat1_wl", 32'(bus.walk_left), 32'hD);
    bus.ground = 4'hD;
    bus.dig = 4'h2;
    bus.bump_left = 4'h2;
    bus.bump_right = 4'h2;
    repeat (4) begin
      cyc(1);
      chk("splat1_hold", 32'(bus.splat), 32'h2);
      chk("splat1_nognt", 32'(bus.gnt_vld), 32'h0);
    end
    bus.ground = 4'hF;
    bus.dig = '0;
    bus.bump_left = '0;
    bus.bump_right = '0;
    cyc(1);
    bus.ground = 4'hE;
    push(0, AA);
    cyc(20);
    bus.ground = 4'hF;
    push(0, WL);
    cyc(1);
    chk("cnt19_wl", 32'(bus.walk_left), 32'hD);
    chk("cnt19_aaah", 32'(bus.aaah), 32'h0);
    bus.ground = 4'h7;
    push(3, AA);
    cyc(21);
    bus.ground = 4'hF;
    push(3, SP);
    cyc(1);
    chk("cnt20_splat", 32'(bus.splat), 32'hA);
    pulse_reset();
    bus.bump_left = 4'h8;
    push(3, WR);
    cyc(1);
    bus.bump_left = '0;
    bus.dig = 4'h8;
    bus.bump_right = 4'h8;
    push(3, DG);
    cyc(1);
    chk("dig3", 32'(bus.digging), 32'h8);
    cyc(1);
    chk("dig3_hold", 32'(bus.digging), 32'h8);
    chk("dig3_nognt", 32'(bus.gnt_vld), 32'h0);
    bus.ground = 4'h7;
    bus.dig = '0;
    bus.bump_right = '0;
    push(3, AA);
    cyc(1);
    chk("dig3_fall", 32'(bus.aaah), 32'h8);
    chk("dig3_fall_wr", 32'(bus.walk_right), 32'h0);
    cyc(3);
    bus.ground = 4'hF;
    push(3, WR);
    cyc(1);
    chk("dig3_land", 32'(bus.walk_right), 32'h8);
    chk("dig3_land_aaah", 32'(bus.aaah), 32'h0);
    bus.ground = 4'h0;
    for (int j = 0; j < N; j++) push(j, AA);
    cyc(21);
    bus.ground = 4'h9;
    push(0, SP);
    push(3, WR);
    cyc(1);
    chk("all_splat0", 32'(bus.splat), 32'h1);
    cyc(1);
    chk("all_lag3_wr", 32'(bus.walk_right), 32'h8);
    bus.ground = 4'hF;
    push(1, SP);
    push(2, SP);
    cyc(2);
    chk("all_splat", 32'(bus.splat), 32'h7);
    chk("all_wr", 32'(bus.walk_right), 32'h8);
    chk("all_aaah", 32'(bus.aaah), 32'h0);
    cyc(3);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
